spr_line_evaluator: RTL

//  Sprite scanline evaluator for the FSX sprite layer.
//  - Scans the sprite attribute table in VRAMSPR once per line, during hblank.
//  - Selects up to MAX_PER_LINE sprites that intersect the next display line.
//  - Writes them to a double-buffered slot table, which the sprite pixel renderer reads during the following line.
//  - Sole sequencer of the vramSPR read port. Runs on the clkMuxOut domain, next to BGWrenderer.

---
 rtl/spr_line_evaluator_pkg.sv | 36 +++
 rtl/spr_slot_bank.sv | 79 +++++++
 rtl/spr_line_evaluator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/spr_line_evaluator_pkg.sv
// Shared GPU sprite package: attribute word offsets, sprite layer defaults,
// evaluator FSM encoding, slot record layout and the line/Y distance helper.
package spr_line_evaluator_pkg;

  localparam int SPR_H_DEF        = 8;
  localparam int MAX_PER_LINE_DEF = 8;

  localparam logic [1:0] SPR_OFF_Y    = 2'd0;
  localparam logic [1:0] SPR_OFF_X    = 2'd1;
  localparam logic [1:0] SPR_OFF_TILE = 2'd2;
  localparam logic [1:0] SPR_OFF_ATTR = 2'd3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD_Y = 3'd1;
  localparam logic [2:0] ST_CK_Y = 3'd2;
  localparam logic [2:0] ST_RD_X = 3'd3;
  localparam logic [2:0] ST_RD_T = 3'd4;
  localparam logic [2:0] ST_RD_A = 3'd5;

  typedef struct packed {
    logic [8:0] x;
    logic [2:0] row;
    logic [7:0] tile;
    logic [8:0] attr;
  } spr_slot_t;

  // Lines below the sprite top, wrapping mod 512 so Y near the
  // bottom of the line space still covers lines 0.. at the top.
  function automatic logic [8:0] spr_ydiff(
    input logic [8:0] ln,
    input logic [8:0] y
  );
    return ln - y;
  endfunction

endpackage

// File: rtl/spr_slot_bank.sv
// Double-buffered sprite slot table: back bank written by the evaluator,
// front bank read combinationally by the renderer; swap flips the banks.
module spr_slot_bank
  import spr_line_evaluator_pkg::*;
#(
  parameter int MAX_PER_LINE = MAX_PER_LINE_DEF,
  localparam int IW = $clog2(MAX_PER_LINE)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clr,
  input  logic          swap,
  input  logic          wr_row,
  input  logic          wr_x,
  input  logic          wr_tile,
  input  logic          wr_attr,
  input  logic          inc,
  input  logic          set_ovf,
  input  logic [2:0]    row_d,
  input  logic [8:0]    q_d,
  output logic [3:0]    back_cnt,
  input  logic [IW-1:0] rd_idx,
  output logic [3:0]    front_cnt,
  output logic          front_ovf,
  output logic [8:0]    slot_x,
  output logic [2:0]    slot_row,
  output logic [7:0]    slot_tile,
  output logic [8:0]    slot_attr
);

  spr_slot_t     slots [2][MAX_PER_LINE];
  logic [3:0]    cnt_q [2];
  logic [1:0]    ovf_q;
  logic          fb;
  logic          bb;
  logic [IW-1:0] wi;
  spr_slot_t     rd;

  assign bb       = ~fb;
  assign back_cnt = cnt_q[bb];
  assign wi       = back_cnt[IW-1:0];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      fb    <= 1'b0;
      ovf_q <= '0;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
        for (int i = 0; i < MAX_PER_LINE; i++)
          slots[b][i] <= '0;
      end
    end else begin
      if (wr_row)  slots[bb][wi].row  <= row_d;
      if (wr_x)    slots[bb][wi].x    <= q_d;
      if (wr_tile) slots[bb][wi].tile <= q_d[7:0];
      if (wr_attr) slots[bb][wi].attr <= q_d;
      // A restart discards whatever the aborted scan left behind.
      if (clr) begin
        cnt_q[bb] <= '0;
        ovf_q[bb] <= 1'b0;
      end else begin
        if (inc)     cnt_q[bb] <= cnt_q[bb] + 4'd1;
        if (set_ovf) ovf_q[bb] <= 1'b1;
      end
      // Count/overflow above land in the old back bank, which
      // becomes the front bank on this same edge.
      if (swap) fb <= bb;
    end
  end

  assign rd        = slots[fb][rd_idx];
  assign front_cnt = cnt_q[fb];
  assign front_ovf = ovf_q[fb];
  assign slot_x    = rd.x;
  assign slot_row  = rd.row;
  assign slot_tile = rd.tile;
  assign slot_attr = rd.attr;

endmodule

// File: rtl/spr_line_evaluator.sv
// Sprite scanline evaluator: scans VRAMSPR during hblank, picks up to
// MAX_PER_LINE sprites for next_line, publishes them via slot_* on done.
module spr_line_evaluator
  import spr_line_evaluator_pkg::*;
#(
  parameter int          NUM_SPRITES  = 64,
  parameter int          MAX_PER_LINE = MAX_PER_LINE_DEF,
  parameter int          SPR_H        = SPR_H_DEF,
  parameter logic [13:0] SPR_BASE     = 14'h0
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        line_start,
  input  logic [8:0]  next_line,
  output logic [13:0] vramSPR_addr,
  input  logic [8:0]  vramSPR_q,
  output logic        busy,
  output logic        done,
  output logic [3:0]  slot_count,
  output logic        overflow,
  input  logic [2:0]  slot_idx,
  output logic [8:0]  slot_x,
  output logic [2:0]  slot_row,
  output logic [7:0]  slot_tile,
  output logic [8:0]  slot_attr
);

  localparam int          NW      = $clog2(NUM_SPRITES);
  localparam logic [NW-1:0] N_LAST = NW'(NUM_SPRITES - 1);
  localparam logic [3:0]  CNT_MAX = 4'(MAX_PER_LINE);

  logic [2:0]    state;
  logic [8:0]    line;
  logic [NW-1:0] n;
  logic          pend;
  logic [13:0]   ent;
  logic [8:0]    diff;
  logic          hit;
  logic          last;
  logic          full;
  logic          fin;
  logic          go;
  logic          clr;
  logic [3:0]    back_cnt;
  logic          wr_row;
  logic          wr_x;
  logic          wr_tile;
  logic          wr_attr;
  logic          inc;
  logic          set_ovf;

  assign ent  = SPR_BASE + 14'({n, 2'b00});
  assign diff = spr_ydiff(line, vramSPR_q);
  assign hit  = diff < 9'(SPR_H);
  assign last = (n == N_LAST);
  assign full = (back_cnt == CNT_MAX);
  assign busy = (state != ST_IDLE);

  always_comb begin
    fin     = 1'b0;
    wr_row  = 1'b0;
    wr_x    = 1'b0;
    wr_tile = 1'b0;
    wr_attr = 1'b0;
    inc     = 1'b0;
    set_ovf = 1'b0;
    unique case (state)
      ST_CK_Y: begin
        wr_row  = hit && !full;
        set_ovf = hit && full;
        fin     = (hit && full) || (!hit && last);
      end
      ST_RD_X: wr_x = 1'b1;
      ST_RD_T: wr_tile = 1'b1;
      ST_RD_A: begin
        wr_attr = 1'b1;
        inc     = 1'b1;
        fin     = last;
      end
      default: ;
    endcase
    // A start coinciding with finish is deferred one cycle via pend
    // so the swap and done of the completed scan go out first.
    go  = line_start || (pend && state == ST_IDLE);
    clr = go && !fin;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state        <= ST_IDLE;
      line         <= '0;
      n            <= '0;
      pend         <= 1'b0;
      vramSPR_addr <= '0;
      done         <= 1'b0;
    end else begin
      done <= fin;
      if (line_start) line <= next_line;
      if (fin) begin
        state <= ST_IDLE;
        pend  <= line_start;
      end else if (go) begin
        state <= ST_RD_Y;
        n     <= '0;
        pend  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: ;
          ST_RD_Y: begin
            vramSPR_addr <= ent + 14'(SPR_OFF_Y);
            state        <= ST_CK_Y;
          end
          ST_CK_Y: begin
            if (hit) begin
              vramSPR_addr <= ent + 14'(SPR_OFF_X);
              state        <= ST_RD_X;
            end else begin
              n     <= n + NW'(1);
              state <= ST_RD_Y;
            end
          end
          ST_RD_X: begin
            vramSPR_addr <= ent + 14'(SPR_OFF_TILE);
            state        <= ST_RD_T;
          end
          ST_RD_T: begin
            vramSPR_addr <= ent + 14'(SPR_OFF_ATTR);
            state        <= ST_RD_A;
          end
          ST_RD_A: begin
            n     <= n + NW'(1);
            state <= ST_RD_Y;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  spr_slot_bank #(
    .MAX_PER_LINE(MAX_PER_LINE)
  ) u_bank (
    .clk       (clk),
    .nreset    (nreset),
    .clr       (clr),
    .swap      (fin),
    .wr_row    (wr_row),
    .wr_x      (wr_x),
    .wr_tile   (wr_tile),
    .wr_attr   (wr_attr),
    .inc       (inc),
    .set_ovf   (set_ovf),
    .row_d     (diff[2:0]),
    .q_d       (vramSPR_q),
    .back_cnt  (back_cnt),
    .rd_idx    (slot_idx),
    .front_cnt (slot_count),
    .front_ovf (overflow),
    .slot_x    (slot_x),
    .slot_row  (slot_row),
    .slot_tile (slot_tile),
    .slot_attr (slot_attr)
  );

endmodule
